// File: rtl/comp_dest_ctrl_pkg.sv
// Shared constants for the compute-operand destination controller.
// Namespace bit positions, target bit indices and FSM encodings.
package comp_dest_ctrl_pkg;

  // Bit positions within a one-hot destination namespace decode.
  localparam int NAMESPACE_BRAM     = 0;
  localparam int NAMESPACE_NEIGHBOR = 1;
  localparam int NAMESPACE_BUS      = 2;
  localparam int NAMESPACE_INTERIM  = 3;

  // Holding-register target indices.
  localparam int TGT_PE_NEIGH = 0;
  localparam int TGT_PU_NEIGH = 1;
  localparam int TGT_PE_BUS   = 2;
  localparam int TGT_GB_BUS   = 3;
  localparam int TGT_INTERIM  = 4;
  localparam int NTGT         = 5;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

endpackage

// File: rtl/comp_dest_ctrl_if.sv
// Result/destination input bundle and holding-register handshakes.
// master: pipeline + consumers; slave: comp_dest_ctrl.
interface comp_dest_ctrl_if #(
  parameter int dataLen  = 32,
  parameter int destNum  = 3,
  parameter int indexLen = 8
);
  logic [dataLen-1:0]       result;
  logic                     result_v;
  logic [(1<<destNum)-1:0]  dest0_decoder_out;
  logic [(1<<destNum)-1:0]  dest1_decoder_out;
  logic [(1<<destNum)-1:0]  dest2_decoder_out;
  logic [indexLen-1:0]      dest0Index;
  logic [indexLen-1:0]      dest1Index;
  logic [indexLen-1:0]      dest2Index;
  logic                     pe_neigh_rd;
  logic                     pu_neigh_rd;
  logic                     pe_bus_rd;
  logic                     gb_bus_rd;
  logic                     interim_rd;
  logic [dataLen-1:0]       pe_neigh_data_out;
  logic [dataLen-1:0]       pu_neigh_data_out;
  logic [dataLen-1:0]       pe_bus_data_out;
  logic [dataLen-1:0]       gb_bus_data_out;
  logic [dataLen-1:0]       interim_out;
  logic                     pe_neigh_data_out_v;
  logic                     pu_neigh_data_out_v;
  logic                     pe_bus_data_out_v;
  logic                     gb_bus_data_out_v;
  logic                     interim_out_v;
  logic                     inst_stall_dest;

  modport master (
    output result, result_v,
    output dest0_decoder_out, dest1_decoder_out, dest2_decoder_out,
    output dest0Index, dest1Index, dest2Index,
    output pe_neigh_rd, pu_neigh_rd, pe_bus_rd, gb_bus_rd, interim_rd,
    input  pe_neigh_data_out, pu_neigh_data_out, pe_bus_data_out,
    input  gb_bus_data_out, interim_out,
    input  pe_neigh_data_out_v, pu_neigh_data_out_v, pe_bus_data_out_v,
    input  gb_bus_data_out_v, interim_out_v,
    input  inst_stall_dest
  );

  modport slave (
    input  result, result_v,
    input  dest0_decoder_out, dest1_decoder_out, dest2_decoder_out,
    input  dest0Index, dest1Index, dest2Index,
    input  pe_neigh_rd, pu_neigh_rd, pe_bus_rd, gb_bus_rd, interim_rd,
    output pe_neigh_data_out, pu_neigh_data_out, pe_bus_data_out,
    output gb_bus_data_out, interim_out,
    output pe_neigh_data_out_v, pu_neigh_data_out_v, pe_bus_data_out_v,
    output gb_bus_data_out_v, interim_out_v,
    output inst_stall_dest
  );
endinterface

// File: rtl/comp_dest_ctrl_out_hold_reg.sv
// Single data/valid holding register; write wins over a same-cycle read.
// Ports: clk, rstn, wr, rd, din -> q, v.
module out_hold_reg #(
  parameter int dataLen = 32
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               wr,
  input  logic               rd,
  input  logic [dataLen-1:0] din,
  output logic [dataLen-1:0] q,
  output logic               v
);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      q <= '0;
      v <= 1'b0;
    end else if (wr) begin
      q <= din;
      v <= 1'b1;
    end else if (rd && v) begin
      v <= 1'b0;
    end
  end

endmodule

// File: rtl/comp_dest_ctrl.sv
// Loads ALU results into five holding registers, stalling when blocked.
// Ports: clk, rstn, io (comp_dest_ctrl_if.slave).
module comp_dest_ctrl
  import comp_dest_ctrl_pkg::*;
#(
  parameter int dataLen  = 32,
  parameter int destNum  = 3,
  parameter int indexLen = 8
) (
  input  logic           clk,
  input  logic           rstn,
  comp_dest_ctrl_if.slave io
);

  localparam int NSW = 1 << destNum;

  state_t             state;
  state_t             state_nxt;
  logic [NTGT-1:0]    need;
  logic [NTGT-1:0]    avail;
  logic [NTGT-1:0]    wr;
  logic [NTGT-1:0]    rd;
  logic [NTGT-1:0]    v;
  logic [NTGT-1:0]    hold_need;
  logic [dataLen-1:0] hold_data;
  logic [dataLen-1:0] commit_data;
  logic               hold_ld;
  logic [dataLen-1:0] q [NTGT];

  function automatic logic [NTGT-1:0] slot_tgt(
    input logic [NSW-1:0] dec,
    input logic           idx0
  );
    logic [NTGT-1:0] t;
    t = '0;
    if (dec[NAMESPACE_NEIGHBOR]) begin
      if (idx0) t[TGT_PU_NEIGH] = 1'b1;
      else      t[TGT_PE_NEIGH] = 1'b1;
    end
    if (dec[NAMESPACE_BUS]) begin
      if (idx0) t[TGT_GB_BUS] = 1'b1;
      else      t[TGT_PE_BUS] = 1'b1;
    end
    if (dec[NAMESPACE_INTERIM]) t[TGT_INTERIM] = 1'b1;
    return t;
  endfunction

  // Only index bit 0 selects between paired registers.
  logic unused_idx;
  assign unused_idx = ^{io.dest0Index[indexLen-1:1],
                        io.dest1Index[indexLen-1:1],
                        io.dest2Index[indexLen-1:1]};

  assign rd = {io.interim_rd, io.gb_bus_rd, io.pe_bus_rd,
               io.pu_neigh_rd, io.pe_neigh_rd};

  always_comb begin
    need  = slot_tgt(io.dest0_decoder_out, io.dest0Index[0])
          | slot_tgt(io.dest1_decoder_out, io.dest1Index[0])
          | slot_tgt(io.dest2_decoder_out, io.dest2Index[0]);
    avail = ~v | rd;
  end

  always_comb begin
    state_nxt   = state;
    wr          = '0;
    hold_ld     = 1'b0;
    commit_data = io.result;
    unique case (state)
      IDLE: begin
        if (io.result_v && (|need)) begin
          if (&(~need | avail)) begin
            wr = need;
          end else begin
            hold_ld   = 1'b1;
            state_nxt = HOLD;
          end
        end
      end
      HOLD: begin
        commit_data = hold_data;
        if (&(~hold_need | avail)) begin
          wr        = hold_need;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      hold_need <= '0;
      hold_data <= '0;
    end else begin
      state <= state_nxt;
      if (hold_ld) begin
        hold_need <= need;
        hold_data <= io.result;
      end
    end
  end

  for (genvar i = 0; i < NTGT; i++) begin : g_reg
    out_hold_reg #(.dataLen(dataLen)) u_reg (
      .clk  (clk),
      .rstn (rstn),
      .wr   (wr[i]),
      .rd   (rd[i]),
      .din  (commit_data),
      .q    (q[i]),
      .v    (v[i])
    );
  end

  assign io.pe_neigh_data_out   = q[TGT_PE_NEIGH];
  assign io.pu_neigh_data_out   = q[TGT_PU_NEIGH];
  assign io.pe_bus_data_out     = q[TGT_PE_BUS];
  assign io.gb_bus_data_out     = q[TGT_GB_BUS];
  assign io.interim_out         = q[TGT_INTERIM];
  assign io.pe_neigh_data_out_v = v[TGT_PE_NEIGH];
  assign io.pu_neigh_data_out_v = v[TGT_PU_NEIGH];
  assign io.pe_bus_data_out_v   = v[TGT_PE_BUS];
  assign io.gb_bus_data_out_v   = v[TGT_GB_BUS];
  assign io.interim_out_v       = v[TGT_INTERIM];
  assign io.inst_stall_dest     = (state == HOLD);

endmodule

// File: tb/tb_comp_dest_ctrl.sv
// Self-checking bench for comp_dest_ctrl.
// Directed scenarios plus a randomized run against a behavioural model.
module tb_comp_dest_ctrl;
  import comp_dest_ctrl_pkg::*;

  localparam int DL = 32;
  localparam int DN = 3;
  localparam int IL = 8;
  localparam int NS = 1 << DN;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  comp_dest_ctrl_if #(.dataLen(DL), .destNum(DN), .indexLen(IL)) bus ();

  comp_dest_ctrl #(.dataLen(DL), .destNum(DN), .indexLen(IL)) dut (
    .clk  (clk),
    .rstn (rstn),
    .io   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model: register contents and a pending-request slot.
  logic [DL-1:0] m_d [5];
  bit   [4:0]    m_v;
  bit            m_stall;
  logic [DL-1:0] m_hd;
  bit   [4:0]    m_hn;

  function automatic bit [4:0] targets(input logic [NS-1:0] dec,
                                       input logic [IL-1:0] idx);
    bit [4:0] t = '0;
    if (dec[NAMESPACE_NEIGHBOR]) t[idx[0] ? 1 : 0] = 1'b1;
    if (dec[NAMESPACE_BUS])      t[idx[0] ? 3 : 2] = 1'b1;
    if (dec[NAMESPACE_INTERIM])  t[4] = 1'b1;
    return t;
  endfunction

  function automatic bit [4:0] dut_v();
    return {bus.interim_out_v, bus.gb_bus_data_out_v,
            bus.pe_bus_data_out_v, bus.pu_neigh_data_out_v,
            bus.pe_neigh_data_out_v};
  endfunction

  function automatic logic [DL-1:0] dut_d(input int i);
    case (i)
      0:       return bus.pe_neigh_data_out;
      1:       return bus.pu_neigh_data_out;
      2:       return bus.pe_bus_data_out;
      3:       return bus.gb_bus_data_out;
      default: return bus.interim_out;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 5; i++) m_d[i] = '0;
    m_v = '0; m_stall = 0; m_hd = '0; m_hn = '0;
  endtask

  // Apply one clock edge worth of the rules to the model state.
  task automatic model_edge();
    bit [4:0] req, rdv;
    logic [DL-1:0] val;
    bit free;
    rdv = {bus.interim_rd, bus.gb_bus_rd, bus.pe_bus_rd,
           bus.pu_neigh_rd, bus.pe_neigh_rd};
    val = bus.result;
    req = '0;
    if (m_stall) begin
      req = m_hn; val = m_hd;
    end else if (bus.result_v) begin
      req = targets(bus.dest0_decoder_out, bus.dest0Index)
          | targets(bus.dest1_decoder_out, bus.dest1Index)
          | targets(bus.dest2_decoder_out, bus.dest2Index);
    end
    free = 1;
    for (int i = 0; i < 5; i++)
      if (req[i] && m_v[i] && !rdv[i]) free = 0;
    m_v = m_v & ~rdv;
    if (req != 0 && free) begin
      for (int i = 0; i < 5; i++)
        if (req[i]) begin m_d[i] = val; m_v[i] = 1'b1; end
      m_stall = 0;
    end else if (req != 0 && !m_stall) begin
      m_stall = 1; m_hn = req; m_hd = val;
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    bus.result = '0; bus.result_v = 1'b0;
    bus.dest0_decoder_out = '0; bus.dest1_decoder_out = '0;
    bus.dest2_decoder_out = '0;
    bus.dest0Index = '0; bus.dest1Index = '0; bus.dest2Index = '0;
    bus.pe_neigh_rd = 0; bus.pu_neigh_rd = 0; bus.pe_bus_rd = 0;
    bus.gb_bus_rd = 0; bus.interim_rd = 0;
  endtask

  function automatic logic [NS-1:0] rand_dec();
    logic [NS-1:0] d;
    int k;
    k = $urandom_range(0, 5);
    d = '0;
    case (k)
      0: d = '0;
      1: d[NAMESPACE_NEIGHBOR] = 1'b1;
      2: d[NAMESPACE_BUS] = 1'b1;
      3: d[NAMESPACE_INTERIM] = 1'b1;
      4: d[NAMESPACE_BRAM] = 1'b1;
      default: d[5] = 1'b1;
    endcase
    return d;
  endfunction

  task automatic rand_inputs();
    bus.result = $urandom;
    bus.result_v = ($urandom_range(0, 9) < 6);
    bus.dest0_decoder_out = rand_dec();
    bus.dest1_decoder_out = rand_dec();
    bus.dest2_decoder_out = rand_dec();
    bus.dest0Index = IL'($urandom);
    bus.dest1Index = IL'($urandom);
    bus.dest2Index = IL'($urandom);
    bus.pe_neigh_rd = $urandom_range(0, 1);
    bus.pu_neigh_rd = $urandom_range(0, 1);
    bus.pe_bus_rd = $urandom_range(0, 1);
    bus.gb_bus_rd = $urandom_range(0, 1);
    bus.interim_rd = $urandom_range(0, 1);
  endtask

  task automatic clear_regs();
    set_idle();
    bus.pe_neigh_rd = 1; bus.pu_neigh_rd = 1; bus.pe_bus_rd = 1;
    bus.gb_bus_rd = 1; bus.interim_rd = 1;
    step();
    set_idle();
  endtask

  // Write one value into a single register through the normal path.
  task automatic fill(input int ns, input bit odd, input logic [DL-1:0] val);
    set_idle();
    bus.result = val; bus.result_v = 1;
    bus.dest0_decoder_out[ns] = 1'b1;
    bus.dest0Index = {7'($urandom), odd};
    step();
    set_idle();
  endtask

  task automatic test_reset();
    rstn = 0;
    for (int c = 0; c < 3; c++) begin
      rand_inputs();
      @(posedge clk); #1;
      n_tests++;
      if (dut_v() !== 5'b0 || bus.inst_stall_dest !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_v: v=%b stall=%b want v=0 stall=0",
                 dut_v(), bus.inst_stall_dest);
      end
      for (int i = 0; i < 5; i++) begin
        n_tests++;
        if (dut_d(i) !== '0) begin
          n_fail++;
          $display("FAIL reset_data[%0d]: got %h want 0", i, dut_d(i));
        end
      end
    end
    model_reset();
    set_idle();
    rstn = 1;
    step();
    bus.result = 32'h11; bus.result_v = 1;
    bus.dest0_decoder_out[NAMESPACE_INTERIM] = 1'b1;
    step();
    set_idle();
    n_tests++;
    if (bus.interim_out !== 32'h11 || bus.interim_out_v !== 1'b1) begin
      n_fail++;
      $display("FAIL first_write: got %h/%b want 11/1",
               bus.interim_out, bus.interim_out_v);
    end
  endtask

  task automatic test_multicast();
    clear_regs();
    bus.result = 32'hA5; bus.result_v = 1;
    bus.dest0_decoder_out[NAMESPACE_NEIGHBOR] = 1'b1;
    bus.dest0Index = IL'($urandom) & 8'hFE;
    bus.dest1_decoder_out[NAMESPACE_BUS] = 1'b1;
    bus.dest1Index = IL'($urandom) | 8'h01;
    bus.dest2_decoder_out[NAMESPACE_INTERIM] = 1'b1;
    step();
    set_idle();
    n_tests++;
    if (dut_v() !== 5'b11001 || bus.inst_stall_dest !== 1'b0) begin
      n_fail++;
      $display("FAIL multicast_v: v=%b stall=%b want 11001/0",
               dut_v(), bus.inst_stall_dest);
    end
    n_tests++;
    if (bus.pe_neigh_data_out !== 32'hA5 || bus.gb_bus_data_out !== 32'hA5 ||
        bus.interim_out !== 32'hA5) begin
      n_fail++;
      $display("FAIL multicast_data: %h %h %h want a5",
               bus.pe_neigh_data_out, bus.gb_bus_data_out, bus.interim_out);
    end
  endtask

  task automatic test_blocking();
    clear_regs();
    fill(NAMESPACE_NEIGHBOR, 1, 32'h01);
    bus.result = 32'h02; bus.result_v = 1;
    bus.dest0_decoder_out[NAMESPACE_NEIGHBOR] = 1'b1;
    bus.dest0Index = 8'h01;
    bus.dest1_decoder_out[NAMESPACE_INTERIM] = 1'b1;
    step();
    n_tests++;
    if (bus.inst_stall_dest !== 1'b1 || bus.interim_out_v !== 1'b0 ||
        bus.pu_neigh_data_out !== 32'h01) begin
      n_fail++;
      $display("FAIL block_enter: stall=%b int_v=%b pu=%h want 1/0/01",
               bus.inst_stall_dest, bus.interim_out_v, bus.pu_neigh_data_out);
    end
    bus.result = 32'h77;
    step();
    step();
    n_tests++;
    if (bus.inst_stall_dest !== 1'b1 || bus.interim_out_v !== 1'b0) begin
      n_fail++;
      $display("FAIL block_hold: stall=%b int_v=%b want 1/0",
               bus.inst_stall_dest, bus.interim_out_v);
    end
    bus.pu_neigh_rd = 1;
    step();
    set_idle();
    n_tests++;
    if (bus.pu_neigh_data_out !== 32'h02 || bus.pu_neigh_data_out_v !== 1'b1 ||
        bus.interim_out !== 32'h02 || bus.interim_out_v !== 1'b1 ||
        bus.inst_stall_dest !== 1'b0) begin
      n_fail++;
      $display("FAIL block_release: pu=%h/%b int=%h/%b stall=%b want 02/1 02/1 0",
               bus.pu_neigh_data_out, bus.pu_neigh_data_out_v,
               bus.interim_out, bus.interim_out_v, bus.inst_stall_dest);
    end
  endtask

  task automatic test_same_cycle();
    clear_regs();
    fill(NAMESPACE_BUS, 0, 32'h07);
    bus.pe_bus_rd = 1;
    bus.result = 32'h08; bus.result_v = 1;
    bus.dest0_decoder_out[NAMESPACE_BUS] = 1'b1;
    bus.dest0Index = 8'h02;
    step();
    set_idle();
    n_tests++;
    if (bus.pe_bus_data_out !== 32'h08 || bus.pe_bus_data_out_v !== 1'b1 ||
        bus.inst_stall_dest !== 1'b0) begin
      n_fail++;
      $display("FAIL rd_wr_same: pe_bus=%h/%b stall=%b want 08/1/0",
               bus.pe_bus_data_out, bus.pe_bus_data_out_v, bus.inst_stall_dest);
    end
  endtask

  task automatic test_reset_hold();
    clear_regs();
    fill(NAMESPACE_INTERIM, 0, 32'h10);
    bus.result = 32'h33; bus.result_v = 1;
    bus.dest0_decoder_out[NAMESPACE_INTERIM] = 1'b1;
    step();
    set_idle();
    n_tests++;
    if (bus.inst_stall_dest !== 1'b1) begin
      n_fail++;
      $display("FAIL hold_enter: stall=%b want 1", bus.inst_stall_dest);
    end
    #2 rstn = 0;
    #2;
    n_tests++;
    if (dut_v() !== 5'b0 || bus.inst_stall_dest !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_reset: v=%b stall=%b want 0/0",
               dut_v(), bus.inst_stall_dest);
    end
    rstn = 1;
    model_reset();
    for (int c = 0; c < 4; c++) begin
      step();
      n_tests++;
      if (dut_v() !== 5'b0 || bus.interim_out === 32'h33 ||
          bus.inst_stall_dest !== 1'b0) begin
        n_fail++;
        $display("FAIL hold_discard: v=%b int=%h stall=%b want 0/!33/0",
                 dut_v(), bus.interim_out, bus.inst_stall_dest);
      end
    end
  endtask

  task automatic test_bram();
    clear_regs();
    fill(NAMESPACE_NEIGHBOR, 0, 32'h5C);
    bus.result = 32'hDEAD; bus.result_v = 1;
    bus.dest0_decoder_out[NAMESPACE_BRAM] = 1'b1;
    bus.dest1_decoder_out[NAMESPACE_BRAM] = 1'b1;
    bus.dest2_decoder_out[5] = 1'b1;
    step();
    set_idle();
    n_tests++;
    if (dut_v() !== 5'b00001 || bus.pe_neigh_data_out !== 32'h5C ||
        bus.inst_stall_dest !== 1'b0) begin
      n_fail++;
      $display("FAIL bram_ignore: v=%b pe_neigh=%h stall=%b want 00001/5c/0",
               dut_v(), bus.pe_neigh_data_out, bus.inst_stall_dest);
    end
  endtask

  task automatic test_random();
    int bad;
    for (int c = 0; c < 400; c++) begin
      rand_inputs();
      step();
      bad = 0;
      if (dut_v() !== m_v || bus.inst_stall_dest !== m_stall) bad = 1;
      for (int i = 0; i < 5; i++)
        if (dut_d(i) !== m_d[i]) bad = 1;
      n_tests++;
      if (bad) begin
        n_fail++;
        $display("FAIL random[%0d]: v=%b stall=%b want v=%b stall=%b",
                 c, dut_v(), bus.inst_stall_dest, m_v, m_stall);
      end
    end
    set_idle();
  endtask

  initial begin
    set_idle();
    model_reset();
    test_reset();
    test_multicast();
    test_blocking();
    test_same_cycle();
    test_reset_hold();
    test_bram();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
